// File: rtl/risc_pkg.sv
// Shared definitions for the RISC datapath and its controller: widths and opcode set.
package risc_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned OPC_W  = 3;

  typedef enum logic [OPC_W-1:0] {
    OP_HLT = 3'b000,
    OP_SKZ = 3'b001,
    OP_ADD = 3'b010,
    OP_AND = 3'b011,
    OP_XOR = 3'b100,
    OP_LDA = 3'b101,
    OP_STO = 3'b110,
    OP_JMP = 3'b111
  } opcode_e;

endpackage

// File: rtl/risc_alu.sv
// Combinational ALU; opcodes that do not write the accumulator pass a through unchanged.
module risc_alu
  import risc_pkg::*;
#(
  parameter int unsigned DATA_W = risc_pkg::DATA_W,
  parameter int unsigned OPC_W  = risc_pkg::OPC_W
) (
  input  logic [OPC_W-1:0]  opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = a;
    case (opcode)
      OPC_W'(OP_ADD): result = a + b;
      OPC_W'(OP_AND): result = a & b;
      OPC_W'(OP_XOR): result = a ^ b;
      OPC_W'(OP_LDA): result = b;
      default:        result = a;
    endcase
  end

endmodule

// File: rtl/risc_datapath.sv
// RISC datapath: PC, IR, AC, sticky halt and bus-error flags, memory interface steering.
module risc_datapath
  import risc_pkg::*;
#(
  parameter int unsigned DATA_W = risc_pkg::DATA_W,
  parameter int unsigned ADDR_W = risc_pkg::ADDR_W,
  parameter int unsigned OPC_W  = risc_pkg::OPC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_pc,
  input  logic              ld_pc,
  input  logic              sel,
  input  logic              rd,
  input  logic              wr,
  input  logic              ld_ir,
  input  logic              ld_ac,
  input  logic              data_e,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [OPC_W-1:0]  opcode,
  output logic              is_zero,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              halt,
  output logic              bus_err,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ac
);

  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] ac_q;
  logic              halt_q;
  logic              err_q;
  logic [DATA_W-1:0] alu_result;
  logic [ADDR_W-1:0] operand;

  assign operand = ir_q[ADDR_W-1:0];
  assign opcode  = ir_q[DATA_W-1 -: OPC_W];

  risc_alu #(
    .DATA_W (DATA_W),
    .OPC_W  (OPC_W)
  ) u_alu (
    .opcode (opcode),
    .a      (ac_q),
    .b      (mem_rdata),
    .result (alu_result)
  );

  // Halt freezes PC/IR/AC; protocol errors are still recorded while halted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q   <= '0;
      ir_q   <= '0;
      ac_q   <= '0;
      halt_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if ((wr && !data_e) || (ld_ir && ld_ac)) begin
        err_q <= 1'b1;
      end
      if (!halt_q) begin
        if (ld_pc) begin
          pc_q <= operand;
        end else if (inc_pc) begin
          pc_q <= pc_q + ADDR_W'(1);
        end
        if (ld_ir) begin
          ir_q <= mem_rdata;
          if (mem_rdata[DATA_W-1 -: OPC_W] == OPC_W'(OP_HLT)) begin
            halt_q <= 1'b1;
          end
        end else if (ld_ac) begin
          ac_q <= alu_result;
        end
      end
    end
  end

  assign mem_addr  = sel ? operand : pc_q;
  assign mem_rd    = rd && !halt_q;
  assign mem_wr    = wr && data_e && !halt_q;
  assign mem_wdata = data_e ? ac_q : '0;
  assign is_zero   = (ac_q == '0);
  assign halt      = halt_q;
  assign bus_err   = err_q;
  assign pc        = pc_q;
  assign ac        = ac_q;

endmodule

// File: tb/tb_risc_datapath.sv
// Directed plus randomized bench for risc_datapath against an arithmetic reference model.
module tb_risc_datapath;

  logic       clk;
  logic       rst;
  logic       inc_pc, ld_pc, sel, rd, wr, ld_ir, ld_ac, data_e;
  logic [7:0] mem_rdata;
  logic [2:0] opcode;
  logic       is_zero;
  logic [4:0] mem_addr;
  logic       mem_rd, mem_wr;
  logic [7:0] mem_wdata;
  logic       halt, bus_err;
  logic [4:0] pc;
  logic [7:0] ac;

  int n_checks;
  int n_fail;

  // Reference state as plain integers
  int m_pc, m_ir, m_ac, m_halt, m_err;

  risc_datapath dut (
    .clk       (clk),
    .rst       (rst),
    .inc_pc    (inc_pc),
    .ld_pc     (ld_pc),
    .sel       (sel),
    .rd        (rd),
    .wr        (wr),
    .ld_ir     (ld_ir),
    .ld_ac     (ld_ac),
    .data_e    (data_e),
    .mem_rdata (mem_rdata),
    .opcode    (opcode),
    .is_zero   (is_zero),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .halt      (halt),
    .bus_err   (bus_err),
    .pc        (pc),
    .ac        (ac)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_pc"},      32'(pc),      32'(m_pc));
    check({tag, "_ac"},      32'(ac),      32'(m_ac));
    check({tag, "_opcode"},  32'(opcode),  32'(m_ir / 32));
    check({tag, "_halt"},    32'(halt),    32'(m_halt));
    check({tag, "_bus_err"}, 32'(bus_err), 32'(m_err));
    check({tag, "_is_zero"}, 32'(is_zero), 32'(m_ac == 0));
  endtask

  // Drive one cycle: inputs after the falling edge, combinational checks, edge, state checks.
  task automatic cycle(input string tag, input bit rst_v, input bit inc, input bit ldpc,
                       input bit sl, input bit rdv, input bit wrv, input bit ldir,
                       input bit ldac, input bit de, input int rdata);
    int exp_addr;
    int opc;
    @(negedge clk);
    rst = rst_v; inc_pc = inc; ld_pc = ldpc; sel = sl; rd = rdv; wr = wrv;
    ld_ir = ldir; ld_ac = ldac; data_e = de; mem_rdata = 8'(rdata);
    #1;
    if (rst_v) begin
      exp_addr = sl ? (m_ir % 32) : m_pc;
      check({tag, "_mem_addr"},  32'(mem_addr),  32'(exp_addr));
      check({tag, "_mem_rd"},    32'(mem_rd),    32'(rdv && m_halt == 0));
      check({tag, "_mem_wr"},    32'(mem_wr),    32'(wrv && de && m_halt == 0));
      check({tag, "_mem_wdata"}, 32'(mem_wdata), de ? 32'(m_ac) : 32'd0);
    end
    @(posedge clk);
    if (!rst_v) begin
      m_pc = 0; m_ir = 0; m_ac = 0; m_halt = 0; m_err = 0;
    end else begin
      if ((wrv && !de) || (ldir && ldac)) m_err = 1;
      if (m_halt == 0) begin
        opc = m_ir / 32;
        if (ldpc)     m_pc = m_ir % 32;
        else if (inc) m_pc = (m_pc + 1) % 32;
        if (ldir) begin
          m_ir = rdata;
          if (rdata / 32 == 0) m_halt = 1;
        end else if (ldac) begin
          case (opc)
            2: m_ac = (m_ac + rdata) % 256;
            3: m_ac = m_ac & rdata;
            4: m_ac = m_ac ^ rdata;
            5: m_ac = rdata;
            default: ;
          endcase
        end
      end
    end
    #1;
    check_state(tag);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    m_pc = 0; m_ir = 0; m_ac = 0; m_halt = 0; m_err = 0;
    rst = 1'b0; inc_pc = 0; ld_pc = 0; sel = 0; rd = 0; wr = 0;
    ld_ir = 0; ld_ac = 0; data_e = 0; mem_rdata = '0;

    //          tag       rst inc ldpc sel rd wr ldir ldac de rdata
    cycle("reset",        0,  0,  0,   0,  0, 0, 0,   0,   0, 0);
    check("reset_is_zero", 32'(is_zero), 32'd1);
    check("reset_mem_rd",  32'(mem_rd),  32'd0);
    check("reset_mem_wr",  32'(mem_wr),  32'd0);
    check("reset_halt",    32'(halt),    32'd0);
    cycle("idle",         1,  0,  0,   0,  0, 0, 0,   0,   0, 0);
    for (int i = 0; i < 3; i++) cycle("inc", 1, 1, 0, 0, 1, 0, 0, 0, 0, 0);

    // Fetch: pre-increment address visible, PC advances at the edge.
    cycle("fetch",        1,  1,  0,   0,  1, 0, 1,   0,   0, 8'hE9);
    check("fetch_pc", 32'(pc), 32'd4);
    cycle("jmp_pri",      1,  1,  1,   1,  0, 0, 0,   0,   0, 0);
    check("jmp_pri_pc", 32'(pc), 32'd9);

    cycle("ld_ir_ff",     1,  0,  0,   0,  0, 0, 1,   0,   0, 8'hFF);
    cycle("jmp31",        1,  0,  1,   1,  0, 0, 0,   0,   0, 0);
    cycle("wrap",         1,  1,  0,   0,  0, 0, 0,   0,   0, 0);
    check("wrap_pc", 32'(pc), 32'd0);

    cycle("ir_lda",       1,  0,  0,   0,  0, 0, 1,   0,   0, 8'hA0);
    cycle("lda_f0",       1,  0,  0,   0,  0, 0, 0,   1,   0, 8'hF0);
    cycle("ir_add",       1,  0,  0,   0,  0, 0, 1,   0,   0, 8'h40);
    cycle("add_20",       1,  0,  0,   0,  0, 0, 0,   1,   0, 8'h20);
    check("add_ac", 32'(ac), 32'h10);
    check("add_is_zero", 32'(is_zero), 32'd0);
    cycle("ir_xor",       1,  0,  0,   0,  0, 0, 1,   0,   0, 8'h80);
    cycle("xor_10",       1,  0,  0,   0,  0, 0, 0,   1,   0, 8'h10);
    check("xor_is_zero", 32'(is_zero), 32'd1);

    cycle("ir_lda2",      1,  0,  0,   0,  0, 0, 1,   0,   0, 8'hA0);
    cycle("lda_5a",       1,  0,  0,   0,  0, 0, 0,   1,   0, 8'h5A);
    cycle("ir_sto",       1,  0,  0,   0,  0, 0, 1,   0,   0, 8'hC7);
    @(negedge clk);
    sel = 1; wr = 1; data_e = 1; ld_ir = 0; ld_ac = 0; inc_pc = 0; ld_pc = 0;
    #1;
    check("sto_addr",  32'(mem_addr),  32'd7);
    check("sto_wr",    32'(mem_wr),    32'd1);
    check("sto_wdata", 32'(mem_wdata), 32'h5A);
    cycle("sto",          1,  0,  0,   1,  0, 1, 0,   0,   1, 0);
    cycle("wr_no_de",     1,  0,  0,   1,  0, 1, 0,   0,   0, 0);
    check("wr_no_de_err", 32'(bus_err), 32'd1);
    cycle("ir_ac_clash",  1,  0,  0,   0,  0, 0, 1,   1,   0, 8'hA3);

    cycle("halt_fetch",   1,  0,  0,   0,  0, 0, 1,   0,   0, 8'h1F);
    check("halt_set", 32'(halt), 32'd1);
    cycle("halted_ops",   1,  1,  0,   0,  1, 1, 0,   1,   1, 8'h33);
    cycle("halted_ldpc",  1,  1,  1,   0,  0, 0, 1,   0,   1, 8'hE1);
    cycle("halt_reset",   0,  1,  1,   0,  0, 1, 1,   0,   1, 8'h00);
    check("halt_reset_halt", 32'(halt), 32'd0);
    check("halt_reset_pc",   32'(pc),   32'd0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      bit r_rst, r_inc, r_ldpc, r_sel, r_rd, r_wr, r_ldir, r_ldac, r_de;
      r_rst  = ($urandom_range(0, 39) != 0);
      r_inc  = 1'($urandom_range(0, 1));
      r_ldpc = ($urandom_range(0, 5) == 0);
      r_sel  = 1'($urandom_range(0, 1));
      r_rd   = 1'($urandom_range(0, 1));
      r_wr   = ($urandom_range(0, 3) == 0);
      r_de   = r_wr ? ($urandom_range(0, 15) != 0) : 1'($urandom_range(0, 1));
      r_ldir = ($urandom_range(0, 3) == 0);
      r_ldac = r_ldir ? ($urandom_range(0, 15) == 0) : 1'($urandom_range(0, 1));
      cycle("rand", r_rst, r_inc, r_ldpc, r_sel, r_rd, r_wr, r_ldir, r_ldac, r_de,
            int'($urandom_range(0, 255)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/risc_datapath.md
RISC_DATAPATH -- requirements
Module: risc_datapath

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-low.
REQ-002 Parameter list, one per line:
- DATA_W, default 8: data/accumulator width.
- ADDR_W, default 5: memory address width.
- OPC_W, default 3: opcode width.
REQ-003 Ports, one per line, with clock and reset first:
- clk  in  1  system clock.
- rst  in  1  synchronous active-low reset.
- inc_pc  in  1  increment PC.
- ld_pc  in  1  load PC from IR operand.
- sel  in  1  address select: 0 = PC, 1 = IR operand.
- rd  in  1  memory read request.
- wr  in  1  memory write request.
- ld_ir  in  1  load IR from mem_rdata.
- ld_ac  in  1  load AC from ALU result.
- data_e  in  1  write-data enable.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_rd.
- opcode  out  OPC_W  IR[7:5].
- is_zero  out  1  AC equals zero.
- mem_addr  out  ADDR_W  memory address.
- mem_rd  out  1  read strobe.
- mem_wr  out  1  write strobe.
- mem_wdata  out  DATA_W  write data.
- halt  out  1  sticky halt flag.
- bus_err  out  1  sticky protocol-error flag.
- pc  out  ADDR_W  program counter, for debug.
- ac  out  DATA_W  accumulator, for debug.

Function
REQ-004 Instruction format SHALL be IR[7:5] = opcode and IR[4:0] = operand address.
REQ-005 Opcodes SHALL be: HLT 000, SKZ 001, ADD 010, AND 011, XOR 100, LDA 101, STO 110, JMP 111.
REQ-006 mem_addr SHALL be combinational: the PC when sel=0, IR[4:0] when sel=1.
REQ-007 PC update SHALL follow this priority each cycle:
- ld_pc loads IR[4:0].
- Otherwise inc_pc gives PC+1 modulo 32 (31 wraps to 0).
- Otherwise PC holds.
REQ-008 When ld_pc and inc_pc are both asserted, ld_pc SHALL win and the increment SHALL be discarded.
REQ-009 In the cycle inc_pc is asserted with sel=0, mem_addr SHALL present the pre-increment PC.
REQ-010 ld_ir SHALL capture mem_rdata into IR at the clock edge.
REQ-011 ld_ac SHALL load the ALU result into AC at the clock edge, per IR opcode:
- ADD: (AC+mem_rdata) mod 256, with the carry discarded.
- AND: bitwise AND.
- XOR: bitwise XOR.
- LDA: mem_rdata.
- All other opcodes: AC holds.
REQ-012 is_zero SHALL be (AC == 0), derived combinationally from the AC register.
REQ-013 mem_rd SHALL equal rd AND NOT halt.
REQ-014 mem_wr SHALL equal wr AND data_e AND NOT halt.
REQ-015 mem_wdata SHALL equal AC whenever data_e=1, and 0 otherwise.
REQ-016 halt SHALL set on the edge where ld_ir captures a word whose bits [7:5] are 000, and SHALL remain set until reset.
REQ-017 While halt=1 the following SHALL all be ignored: inc_pc, ld_pc, ld_ir, ld_ac and wr. PC, IR and AC SHALL freeze.
REQ-018 bus_err SHALL set when wr=1 while data_e=0, or when ld_ir and ld_ac are asserted in the same cycle. It SHALL remain set until reset.
REQ-019 When the same-cycle ld_ir and ld_ac condition of REQ-018 occurs, ld_ir SHALL take effect and ld_ac SHALL be ignored.
REQ-020 All state updates SHALL occur on the rising edge of clk; the block SHALL have no other latency.

Reset
REQ-021 While rst=0 at a clock edge, the block SHALL set PC=0, IR=0, AC=0, halt=0 and bus_err=0.
REQ-022 IR=0 at reset SHALL NOT set halt.
REQ-023 Reset SHALL override every control input, including reset asserted mid-instruction and reset asserted while halted.
REQ-024 After reset, is_zero SHALL read 1, mem_rd and mem_wr SHALL read 0 (given rd=wr=0), and opcode SHALL read 000.

Structure
REQ-025 A shared package SHALL hold the opcode enumeration, DATA_W, ADDR_W and OPC_W, for common use by the controller and this block.
REQ-026 The ALU SHALL be a combinational sub-module named risc_alu, with ports opcode, a, b and result.
REQ-027 All state in the block SHALL be PC, IR, AC, halt and bus_err.

Verification
REQ-028 Fetch: PC=3, sel=0, inc_pc=1 -> mem_addr=3 in that cycle, PC=4 next cycle.
REQ-029 Wrap and priority:
- PC=31, inc_pc=1 -> PC=0.
- IR=0xE9, ld_pc=1 with inc_pc=1 -> PC=9.
REQ-030 ALU:
- AC=0xF0, IR opcode ADD, mem_rdata=0x20, ld_ac -> AC=0x10, is_zero=0.
- XOR with 0x10 -> AC=0x00, is_zero=1.
REQ-031 Store: AC=0x5A, sel=1, IR=0xC7, wr=1, data_e=1 -> mem_addr=7, mem_wr=1, mem_wdata=0x5A.
- wr=1 with data_e=0 -> mem_wr=0 and bus_err=1.
REQ-032 Halt: ld_ir with mem_rdata=0x1F -> halt=1.
- Subsequent inc_pc, ld_ac and wr -> PC, AC unchanged and mem_wr=0.
- rst=0 for one edge -> all state 0 and halt=0.
